// File: rtl/bnn_conv_multi_kernel.sv
// Binary XNOR-popcount 3x3 convolution over a stream of NxN matrices, NUM_K kernels per matrix.
// Optional macro THRESH_PROG_EN: per-kernel threshold from weight bits[12:9]; otherwise T is fixed at 5.
module bnn_conv_multi_kernel #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int MAX_DIM = 16,
    parameter int NUM_K   = 2,
    parameter int WBASE   = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);
    localparam int DIM_W = $clog2(MAX_DIM + 1);
    localparam int K_W   = (NUM_K > 1) ? $clog2(NUM_K) : 1;
    localparam int WC_W  = $clog2(NUM_K + 2);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, LOADW, HDR, FILL, ROW, NEXT, DONE} state_t;

    state_t              state, state_nxt;
    logic                busy_nxt, error_nxt, wr_en_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt, wr_addr_nxt, w_addr_nxt;
    logic [DATA_W-1:0]   wr_data_nxt;
    logic [ADDR_W-1:0]   base, base_nxt, wr_ptr, wr_ptr_nxt;
    logic [DIM_W-1:0]    dim, dim_nxt, row_cnt, row_nxt;
    logic [1:0]          fill_cnt, fill_nxt;
    logic [K_W-1:0]      k_idx, k_nxt, w_sel;
    logic [WC_W-1:0]     w_cnt, wcnt_nxt;
    logic                shift_en, w_load;

    logic [8:0]          taps [NUM_K];
    logic [8:0]          cur_taps;
    logic [3:0]          thr;
    logic [3:0]          pop;
    logic [MAX_DIM-1:0]  win_top, win_mid;
    logic [2:0][MAX_DIM-1:0] rows;
    logic [DATA_W-1:0]   row_word;
    logic [7:0]          hdr_dim;

`ifdef THRESH_PROG_EN
    logic [3:0] thresh [NUM_K];
    logic       unused_wbits;
    assign thr          = thresh[k_idx];
    assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:13];
`else
    logic       unused_wbits;
    assign thr          = 4'd5;
    assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:9];
`endif

    assign hdr_dim  = sram_dut_read_data[7:0];
    assign cur_taps = taps[k_idx];
    // Window is the two buffered rows plus the row arriving from SRAM this cycle.
    assign rows     = {sram_dut_read_data[MAX_DIM-1:0], win_mid, win_top};

    always_comb begin
        row_word = '0;
        pop      = '0;
        for (int c = 0; c < MAX_DIM - 2; c++) begin
            pop = '0;
            for (int r = 0; r < 3; r++) begin
                for (int x = 0; x < 3; x++) begin
                    pop = pop + {3'b000, cur_taps[3*r+x] ~^ rows[r][c+x]};
                end
            end
            if (c < int'(dim) - 2) begin
                row_word[c] = (pop >= thr);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_nxt   = state;
        busy_nxt    = dut_busy;
        error_nxt   = dut_error;
        rd_addr_nxt = dut_sram_read_address;
        w_addr_nxt  = dut_wmem_read_address;
        wr_addr_nxt = dut_sram_write_address;
        wr_data_nxt = dut_sram_write_data;
        wr_en_nxt   = 1'b0;
        base_nxt    = base;
        dim_nxt     = dim;
        row_nxt     = row_cnt;
        fill_nxt    = fill_cnt;
        k_nxt       = k_idx;
        wcnt_nxt    = w_cnt;
        wr_ptr_nxt  = wr_ptr;
        shift_en    = 1'b0;
        w_load      = 1'b0;
        w_sel       = '0;

        unique case (state)
            IDLE: begin
                if (dut_run) begin
                    state_nxt   = LOADW;
                    busy_nxt    = 1'b1;
                    error_nxt   = 1'b0;
                    w_addr_nxt  = ADDR_W'(WBASE);
                    wcnt_nxt    = '0;
                    rd_addr_nxt = '0;
                    base_nxt    = '0;
                    wr_ptr_nxt  = '0;
                end
            end
            LOADW: begin
                w_addr_nxt = dut_wmem_read_address + A_ONE;
                wcnt_nxt   = w_cnt + WC_W'(1);
                w_load     = (w_cnt != '0);
                w_sel      = K_W'(w_cnt - WC_W'(1));
                if (w_cnt == WC_W'(NUM_K)) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (sram_dut_read_data == DATA_W'(16'h00FF)) begin
                    state_nxt = DONE;
                end else if (hdr_dim < 8'd3 || hdr_dim > 8'(MAX_DIM)) begin
                    error_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    dim_nxt     = DIM_W'(hdr_dim);
                    k_nxt       = '0;
                    fill_nxt    = '0;
                    rd_addr_nxt = base + A_ONE;
                    state_nxt   = FILL;
                end
            end
            FILL: begin
                // First FILL cycle only presents row 0's address; data follows a cycle later.
                rd_addr_nxt = dut_sram_read_address + A_ONE;
                fill_nxt    = fill_cnt + 2'd1;
                shift_en    = (fill_cnt != 2'd0);
                if (fill_cnt == 2'd2) begin
                    row_nxt   = '0;
                    state_nxt = ROW;
                end
            end
            ROW: begin
                shift_en    = 1'b1;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = wr_ptr;
                wr_data_nxt = row_word;
                wr_ptr_nxt  = wr_ptr + A_ONE;
                row_nxt     = row_cnt + DIM_W'(1);
                // On the last row the read address already points at the next header; hold it.
                if (row_cnt == dim - DIM_W'(3)) begin
                    state_nxt = NEXT;
                end else begin
                    rd_addr_nxt = dut_sram_read_address + A_ONE;
                end
            end
            NEXT: begin
                if (k_idx == K_W'(NUM_K - 1)) begin
                    base_nxt  = base + ADDR_W'(dim) + A_ONE;
                    state_nxt = HDR;
                end else begin
                    k_nxt       = k_idx + K_W'(1);
                    rd_addr_nxt = base + A_ONE;
                    fill_nxt    = '0;
                    state_nxt   = FILL;
                end
            end
            DONE: begin
                if (!dut_sram_write_enable) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_b) begin
            state                  <= IDLE;
            dut_busy               <= 1'b0;
            dut_error              <= 1'b0;
            dut_sram_read_address  <= '0;
            dut_sram_write_address <= '0;
            dut_sram_write_data    <= '0;
            dut_sram_write_enable  <= 1'b0;
            dut_wmem_read_address  <= '0;
            base                   <= '0;
            dim                    <= '0;
            row_cnt                <= '0;
            fill_cnt               <= '0;
            k_idx                  <= '0;
            w_cnt                  <= '0;
            wr_ptr                 <= '0;
        end else begin
            state                  <= state_nxt;
            dut_busy               <= busy_nxt;
            dut_error              <= error_nxt;
            dut_sram_read_address  <= rd_addr_nxt;
            dut_sram_write_address <= wr_addr_nxt;
            dut_sram_write_data    <= wr_data_nxt;
            dut_sram_write_enable  <= wr_en_nxt;
            dut_wmem_read_address  <= w_addr_nxt;
            base                   <= base_nxt;
            dim                    <= dim_nxt;
            row_cnt                <= row_nxt;
            fill_cnt               <= fill_nxt;
            k_idx                  <= k_nxt;
            w_cnt                  <= wcnt_nxt;
            wr_ptr                 <= wr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            win_top <= '0;
            win_mid <= '0;
        end else if (shift_en) begin
            win_top <= win_mid;
            win_mid <= sram_dut_read_data[MAX_DIM-1:0];
        end
    end

    // NOTE: the weight bank is only NUM_K small registers, so clearing it on reset is cheap and keeps state deterministic.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            for (int i = 0; i < NUM_K; i++) begin
                taps[i] <= '0;
`ifdef THRESH_PROG_EN
                thresh[i] <= '0;
`endif
            end
        end else if (w_load) begin
            taps[w_sel] <= wmem_dut_read_data[8:0];
`ifdef THRESH_PROG_EN
            thresh[w_sel] <= wmem_dut_read_data[12:9];
`endif
        end
    end

endmodule

// File: tb/tb_bnn_conv_multi_kernel.sv
// Self-checking bench for bnn_conv_multi_kernel: directed and random streams against
// a behavioural model that evaluates each output pixel straight from the memory images.
module tb_bnn_conv_multi_kernel;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int MAX_DIM = 16;
    localparam int NUM_K   = 2;
    localparam int WBASE   = 1;

    logic              clk = 1'b0;
    logic              reset_b = 1'b1;
    logic              dut_run = 1'b0;
    logic              dut_busy, dut_error;
    logic [ADDR_W-1:0] dut_sram_read_address, dut_sram_write_address, dut_wmem_read_address;
    logic [DATA_W-1:0] sram_dut_read_data, dut_sram_write_data, wmem_dut_read_data;
    logic              dut_sram_write_enable;

    logic [15:0] sram [4096];
    logic [15:0] wmem [4096];

    typedef struct { int addr; int data; int pass_id; } exp_t;
    typedef struct { int addr; int data; int cyc; } got_t;
    exp_t exp_q[$];
    got_t got_q[$];
    bit   exp_err;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fill_ptr = 0;

    always #5 clk = ~clk;

    bnn_conv_multi_kernel #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DIM(MAX_DIM), .NUM_K(NUM_K), .WBASE(WBASE)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .dut_run(dut_run),
        .dut_busy(dut_busy),
        .dut_error(dut_error),
        .dut_sram_read_address(dut_sram_read_address),
        .sram_dut_read_data(sram_dut_read_data),
        .dut_sram_write_address(dut_sram_write_address),
        .dut_sram_write_data(dut_sram_write_data),
        .dut_sram_write_enable(dut_sram_write_enable),
        .dut_wmem_read_address(dut_wmem_read_address),
        .wmem_dut_read_data(wmem_dut_read_data)
    );

    always_ff @(posedge clk) begin
        sram_dut_read_data <= sram[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dut_sram_write_enable === 1'b1)
            got_q.push_back('{int'(dut_sram_write_address), int'(dut_sram_write_data), cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int got_data(input int i);
        if (i < got_q.size()) return got_q[i].data;
        return -1;
    endfunction

    // Reference: walk the stream, apply every kernel to every 3x3 window.
    function automatic void model();
        int a = 0, wa = 0, pass_id = 0;
        exp_q.delete();
        exp_err = 1'b0;
        for (int m = 0; m < 64; m++) begin
            int hdr = int'(sram[a]);
            int n = hdr & 'hFF;
            if (hdr == 'hFF) break;
            if (n < 3 || n > MAX_DIM) begin
                exp_err = 1'b1;
                break;
            end
            for (int k = 0; k < NUM_K; k++) begin
                int tp = int'(wmem[WBASE+k]) & 'h1FF;
                int t;
`ifdef THRESH_PROG_EN
                t = (int'(wmem[WBASE+k]) >> 9) & 'hF;
`else
                t = 5;
`endif
                for (int r = 0; r < n - 2; r++) begin
                    int word = 0;
                    for (int c = 0; c < n - 2; c++) begin
                        int ones = 0;
                        for (int dr = 0; dr < 3; dr++)
                            for (int dc = 0; dc < 3; dc++)
                                if (((tp >> (3*dr + dc)) & 1) == ((int'(sram[a+1+r+dr]) >> (c + dc)) & 1))
                                    ones++;
                        if (ones >= t) word |= (1 << c);
                    end
                    exp_q.push_back('{wa, word, pass_id});
                    wa++;
                end
                pass_id++;
            end
            a += n + 1;
        end
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            sram[i] = '0;
            wmem[i] = 16'($urandom);
        end
        fill_ptr = 0;
    endtask

    task automatic add_matrix(input int n, input int mode);
        sram[fill_ptr] = 16'(n);
        for (int r = 0; r < n; r++)
            sram[fill_ptr+1+r] = (mode == 0) ? 16'($urandom) : (mode == 1 ? 16'h000F : 16'h0000);
        fill_ptr += n + 1;
    endtask

    task automatic run_dut(input int repulse_at, output int busy_cycles);
        model();
        got_q.delete();
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        check("busy_rise", dut_busy, 1);
        check("err_clear", dut_error, 0);
        busy_cycles = 0;
        while (dut_busy === 1'b1 && busy_cycles < 5000) begin
            busy_cycles++;
            dut_run = (busy_cycles == repulse_at);
            @(negedge clk);
        end
        dut_run = 1'b0;
        check("busy_fall", dut_busy, 0);
    endtask

    task automatic compare_run(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            if (i > 0 && exp_q[i].pass_id == exp_q[i-1].pass_id)
                check({tag, "_gap"}, got_q[i].cyc - got_q[i-1].cyc, 1);
        end
        check({tag, "_err"}, dut_error, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int v;
        int t10_exp;
        clear_mem();
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        check("rst_busy", dut_busy, 0);
        check("rst_err", dut_error, 0);
        check("rst_we", dut_sram_write_enable, 0);
        check("rst_raddr", dut_sram_read_address, 0);
        check("rst_waddr", dut_sram_write_address, 0);
        check("rst_wmaddr", dut_wmem_read_address, 0);

        // N=4 all-ones image, all-ones taps, T=5
        clear_mem();
        add_matrix(4, 1);
        sram[fill_ptr] = 16'h00FF;
        wmem[1] = 16'((5 << 9) | 'h1FF);
        wmem[2] = 16'((5 << 9) | 'h1FF);
        run_dut(0, bc);
        compare_run("single");
        check("single_w0", got_data(0), 3);
        check("single_w1", got_data(1), 3);

        // Complementary kernels on a random N=10 image
        clear_mem();
        add_matrix(10, 0);
        sram[fill_ptr] = 16'h00FF;
        v = int'($urandom_range(0, 511));
        wmem[1] = 16'((5 << 9) | v);
        wmem[2] = 16'((5 << 9) | (~v & 'h1FF));
        run_dut(0, bc);
        compare_run("twok");
        check("twok_count16", got_q.size(), 16);
        for (int i = 0; i < 8; i++)
            check("twok_compl", got_data(8 + i), (~exp_q[i].data) & 'hFF);

        // Multi-matrix stream 16, 12, 10
        clear_mem();
        add_matrix(16, 0);
        add_matrix(12, 0);
        add_matrix(10, 0);
        sram[fill_ptr] = 16'h00FF;
        run_dut(0, bc);
        compare_run("multi");
        check("multi_count64", got_q.size(), 64);

        // Invalid second header
        clear_mem();
        add_matrix(5, 0);
        sram[fill_ptr] = 16'h0002;
        run_dut(0, bc);
        compare_run("inval");
        check("inval_err", dut_error, 1);

        // Empty stream; also clears the sticky error
        clear_mem();
        sram[0] = 16'h00FF;
        run_dut(0, bc);
        compare_run("empty");
        check("empty_busy_le6", bc <= 6, 1);

        // Threshold corners on an all-zero image with zero taps
        clear_mem();
        add_matrix(5, 2);
        sram[fill_ptr] = 16'h00FF;
        wmem[1] = 16'(9 << 9);
        wmem[2] = 16'(9 << 9);
        run_dut(0, bc);
        compare_run("t9");
        check("t9_w0", got_data(0), 'h7);
        wmem[1] = 16'(10 << 9);
        wmem[2] = 16'(10 << 9);
`ifdef THRESH_PROG_EN
        t10_exp = 0;
`else
        t10_exp = 'h7;
`endif
        run_dut(0, bc);
        compare_run("t10");
        check("t10_w0", got_data(0), t10_exp);

        // Random streams, some with a dut_run pulse while busy
        for (int it = 0; it < 6; it++) begin
            clear_mem();
            for (int m = 0; m < int'($urandom_range(1, 3)); m++)
                add_matrix(int'($urandom_range(3, MAX_DIM)), 0);
            sram[fill_ptr] = 16'h00FF;
            run_dut((it % 2 == 0) ? 7 : 0, bc);
            compare_run("rand");
        end

        // Reset in the middle of a 16x16 pass
        clear_mem();
        add_matrix(16, 0);
        sram[fill_ptr] = 16'h00FF;
        got_q.delete();
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        v = 0;
        while (got_q.size() < 3 && v < 500) begin
            @(negedge clk);
            v++;
        end
        check("rst_reach_row", got_q.size() >= 3, 1);
        reset_b = 1'b1;
        @(negedge clk);
        check("mrst_busy", dut_busy, 0);
        check("mrst_we", dut_sram_write_enable, 0);
        check("mrst_raddr", dut_sram_read_address, 0);
        check("mrst_waddr", dut_sram_write_address, 0);
        check("mrst_wmaddr", dut_wmem_read_address, 0);
        got_q.delete();
        repeat (20) @(negedge clk);
        check("mrst_nowrite", got_q.size(), 0);
        reset_b = 1'b0;
        @(negedge clk);
        run_dut(0, bc);
        compare_run("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
